// File: rtl/fpnorm_if.sv
// Handshake and datapath bundle between the add/mul datapath, fpnorm and the rounder.
// in_flush exists only when FPNORM_FLUSH_EN is defined.
interface fpnorm_if;
    logic        in_vld;
    logic        in_rdy;
    logic        in_sign;
    logic [15:0] in_exp;
    logic [67:0] in_mant;
    logic [2:0]  in_rmode;
    logic        in_isDBL;
    logic        in_isEXT;
    logic        in_toDBL;
    logic        in_toSNG;
`ifdef FPNORM_FLUSH_EN
    logic        in_flush;
`endif
    logic        out_vld;
    logic        out_rdy;
    logic [80:0] out_A;
    logic        out_rbit;
    logic        out_tail;
    logic        out_rndbit;
    logic [2:0]  out_rmode;
    logic        out_isDBL;
    logic        out_isEXT;
    logic        out_toDBL;
    logic        out_toSNG;
    logic        out_zero;
    logic        out_oflow;

    // Valid/ready: a transfer happens on a rising clk edge where vld and rdy are both 1;
    // the producer keeps vld and its payload steady until that edge.
    modport master (
`ifdef FPNORM_FLUSH_EN
        output in_flush,
`endif
        output in_vld, in_sign, in_exp, in_mant, in_rmode,
        output in_isDBL, in_isEXT, in_toDBL, in_toSNG, out_rdy,
        input  in_rdy, out_vld, out_A, out_rbit, out_tail, out_rndbit, out_rmode,
        input  out_isDBL, out_isEXT, out_toDBL, out_toSNG, out_zero, out_oflow
    );

    modport slave (
`ifdef FPNORM_FLUSH_EN
        input  in_flush,
`endif
        input  in_vld, in_sign, in_exp, in_mant, in_rmode,
        input  in_isDBL, in_isEXT, in_toDBL, in_toSNG, out_rdy,
        output in_rdy, out_vld, out_A, out_rbit, out_tail, out_rndbit, out_rmode,
        output out_isDBL, out_isEXT, out_toDBL, out_toSNG, out_zero, out_oflow
    );
endinterface

// File: rtl/fpnorm.sv
// Two-stage normaliser feeding the FP rounder: carry fix + LZC, then clamped shift and round-bit extraction.
// Optional pipeline flush is enabled by defining FPNORM_FLUSH_EN.
module fpnorm (
    input logic    clk,
    input logic    rst,
    fpnorm_if.slave bus
);
    logic        w_kill, w_s2_load, w_s1_acc;
    logic        w_carry, w_esat, w_sticky0, w_oflow1;
    logic [66:0] w_m1;
    logic [15:0] w_e1;
    logic [6:0]  w_lzc;

    logic        r_s1v, r_s1_sign, r_s1_sticky, r_s1_oflow;
    logic [15:0] r_s1_exp;
    logic [66:0] r_s1_m;
    logic [6:0]  r_s1_lzc;
    logic [2:0]  r_s1_rmode;
    logic [3:0]  r_s1_fmt;

    logic        r_s2v, r_rbit, r_tail, r_rndbit, r_zero, r_oflow;
    logic [80:0] r_out_A;
    logic [2:0]  r_rmode;
    logic [3:0]  r_fmt;

`ifdef FPNORM_FLUSH_EN
    assign w_kill = bus.in_flush;
`else
    assign w_kill = 1'b0;
`endif

    assign w_s2_load  = !r_s2v || bus.out_rdy;
    assign bus.in_rdy = !r_s1v || w_s2_load;
    assign w_s1_acc   = bus.in_vld && bus.in_rdy && !w_kill;

    // Stage 1: fold the carry-out back into the integer position.
    assign w_carry   = bus.in_mant[67];
    assign w_esat    = (bus.in_exp == 16'hFFFF);
    assign w_m1      = w_carry ? bus.in_mant[67:1] : bus.in_mant[66:0];
    assign w_sticky0 = w_carry && bus.in_mant[0];
    assign w_oflow1  = w_carry && w_esat;
    assign w_e1      = !w_carry ? bus.in_exp : (w_esat ? 16'hFFFF : bus.in_exp + 16'd1);

    always_comb begin
        w_lzc = 7'd67;
        for (int i = 0; i < 67; i++) begin
            if (w_m1[i]) w_lzc = 7'(66 - i);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1v <= 1'b0;
        end else begin
            r_s1v <= !w_kill && (w_s1_acc || (r_s1v && !w_s2_load));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1_sign   <= 1'b0;
            r_s1_exp    <= '0;
            r_s1_m      <= '0;
            r_s1_sticky <= 1'b0;
            r_s1_lzc    <= '0;
            r_s1_oflow  <= 1'b0;
            r_s1_rmode  <= '0;
            r_s1_fmt    <= '0;
        end else if (w_s1_acc) begin
            r_s1_sign   <= bus.in_sign;
            r_s1_exp    <= w_e1;
            r_s1_m      <= w_m1;
            r_s1_sticky <= w_sticky0;
            r_s1_lzc    <= w_lzc;
            r_s1_oflow  <= w_oflow1;
            r_s1_rmode  <= bus.in_rmode;
            r_s1_fmt    <= {bus.in_isDBL, bus.in_isEXT, bus.in_toDBL, bus.in_toSNG};
        end
    end

    // Stage 2: the shift is clamped so the exponent bottoms out at zero.
    logic        w_zero;
    logic [6:0]  w_sh;
    logic [66:0] w_norm;
    logic [15:0] w_e2;
    logic [63:0] w_mant;
    logic        w_rbit, w_tail, w_rndbit;

    assign w_zero = (r_s1_m == 67'd0);
    assign w_sh   = ({9'd0, r_s1_lzc} > r_s1_exp) ? r_s1_exp[6:0] : r_s1_lzc;
    assign w_norm = r_s1_m << w_sh;
    assign w_e2   = w_zero ? 16'd0 : r_s1_exp - {9'd0, w_sh};

    // fmt = {isDBL, isEXT, toDBL, toSNG}; conversion targets win over the source format.
    always_comb begin
        w_mant   = '0;
        w_rndbit = 1'b0;
        w_rbit   = 1'b0;
        w_tail   = 1'b0;
        if (r_s1_fmt[0] || !(r_s1_fmt[1] || r_s1_fmt[2] || r_s1_fmt[3])) begin
            w_mant   = {w_norm[66:43], 40'd0};
            w_rndbit = w_norm[43];
            w_rbit   = w_norm[42];
            w_tail   = |w_norm[41:0];
        end else if (r_s1_fmt[1] || !r_s1_fmt[2]) begin
            w_mant   = {w_norm[66:14], 11'd0};
            w_rndbit = w_norm[14];
            w_rbit   = w_norm[13];
            w_tail   = |w_norm[12:0];
        end else begin
            w_mant   = w_norm[66:3];
            w_rndbit = w_norm[3];
            w_rbit   = w_norm[2];
            w_tail   = |w_norm[1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s2v <= 1'b0;
        end else if (w_kill) begin
            r_s2v <= 1'b0;
        end else if (w_s2_load) begin
            r_s2v <= r_s1v;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_A  <= '0;
            r_rbit   <= 1'b0;
            r_tail   <= 1'b0;
            r_rndbit <= 1'b0;
            r_rmode  <= '0;
            r_fmt    <= '0;
            r_zero   <= 1'b0;
            r_oflow  <= 1'b0;
        end else if (w_s2_load && r_s1v && !w_kill) begin
            r_out_A  <= {r_s1_sign, w_e2, w_mant};
            r_rbit   <= w_rbit;
            r_tail   <= w_tail | r_s1_sticky;
            r_rndbit <= w_rndbit;
            r_rmode  <= r_s1_rmode;
            r_fmt    <= r_s1_fmt;
            r_zero   <= w_zero;
            r_oflow  <= r_s1_oflow && !w_zero;
        end
    end

    assign bus.out_vld    = r_s2v;
    assign bus.out_A      = r_out_A;
    assign bus.out_rbit   = r_rbit;
    assign bus.out_tail   = r_tail;
    assign bus.out_rndbit = r_rndbit;
    assign bus.out_rmode  = r_rmode;
    assign bus.out_isDBL  = r_fmt[3];
    assign bus.out_isEXT  = r_fmt[2];
    assign bus.out_toDBL  = r_fmt[1];
    assign bus.out_toSNG  = r_fmt[0];
    assign bus.out_zero   = r_zero;
    assign bus.out_oflow  = r_oflow;
endmodule

// File: tb/tb_fpnorm.sv
// Directed scoreboard bench for fpnorm: stimulus pushes expected results, a monitor pops on each output transfer.
module tb_fpnorm;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    int   n_waits;
    logic [92:0] exp_q[$];

    fpnorm_if bus();

    fpnorm dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {A, rbit, tail, rndbit, rmode, isDBL, isEXT, toDBL, toSNG, zero, oflow}
    function automatic logic [92:0] pk(input logic [80:0] a, input logic rb, input logic t,
                                       input logic rnd, input logic [2:0] rm, input logic [3:0] fl,
                                       input logic z, input logic o);
        return {a, rb, t, rnd, rm, fl, z, o};
    endfunction

    function automatic logic [92:0] dut_out();
        return pk(bus.out_A, bus.out_rbit, bus.out_tail, bus.out_rndbit, bus.out_rmode,
                  {bus.out_isDBL, bus.out_isEXT, bus.out_toDBL, bus.out_toSNG},
                  bus.out_zero, bus.out_oflow);
    endfunction

    task automatic chk(input string name, input logic [92:0] act, input logic [92:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // driver
    task automatic send(input logic s, input logic [15:0] e, input logic [67:0] m,
                        input logic [2:0] rm, input logic [3:0] fl, input logic [92:0] ev);
        int   waits;
        logic acc;
        bus.in_vld   = 1'b1;
        bus.in_sign  = s;
        bus.in_exp   = e;
        bus.in_mant  = m;
        bus.in_rmode = rm;
        {bus.in_isDBL, bus.in_isEXT, bus.in_toDBL, bus.in_toSNG} = fl;
        exp_q.push_back(ev);
        waits = 0;
        acc   = 1'b0;
        while (!acc && waits < 50) begin
            @(negedge clk);
            acc = bus.in_rdy;
            @(posedge clk);
            #1;
            if (!acc) waits++;
        end
        chk("accept", {92'd0, acc}, 93'd1);
        n_waits += waits;
        bus.in_vld = 1'b0;
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (rst && bus.out_vld && bus.out_rdy) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("[TB] FAIL unexpected_out: got %h expected none", dut_out());
            end else begin
                chk("result", dut_out(), exp_q.pop_front());
            end
        end
    end

    logic [92:0] snap;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        n_waits = 0;
        rst = 1'b0;
        bus.in_vld = 1'b0; bus.in_sign = 1'b0; bus.in_exp = '0; bus.in_mant = '0;
        bus.in_rmode = '0; bus.in_isDBL = 1'b0; bus.in_isEXT = 1'b0;
        bus.in_toDBL = 1'b0; bus.in_toSNG = 1'b0; bus.out_rdy = 1'b1;
`ifdef FPNORM_FLUSH_EN
        bus.in_flush = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_vld", {92'd0, bus.out_vld}, 93'd0);
        chk("rst_in_rdy", {92'd0, bus.in_rdy}, 93'd1);
        chk("rst_outputs", dut_out(), 93'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // back-to-back directed vectors with out_rdy held high
        n_waits = 0;
        send(0, 16'h4000, 68'h0_0000_0001_0000_0000, 3'b010, 4'b0100,
             pk({1'b0, 16'h3FDE, 64'h8000_0000_0000_0000}, 0, 0, 0, 3'b010, 4'b0100, 0, 0));
        send(0, 16'h3FFF, (68'd1 << 67) | 68'd1, 3'b000, 4'b1000,
             pk({1'b0, 16'h4000, 64'h8000_0000_0000_0000}, 0, 1, 0, 3'b000, 4'b1000, 0, 0));
        send(0, 16'h0003, 68'd1 << 60, 3'b001, 4'b0000,
             pk({1'b0, 16'h0000, 64'h1000_0000_0000_0000}, 0, 0, 0, 3'b001, 4'b0000, 0, 0));
        send(1, 16'h1234, 68'd0, 3'b111, 4'b1010,
             pk(81'h1_0000_0000_0000_0000_0000, 0, 0, 0, 3'b111, 4'b1010, 1, 0));
        send(0, 16'h4000, (68'd1 << 66) | (68'd1 << 43) | (68'd1 << 42) | (68'd1 << 5), 3'b011, 4'b0101,
             pk({1'b0, 16'h4000, 64'h8000_0100_0000_0000}, 1, 1, 1, 3'b011, 4'b0101, 0, 0));
        send(0, 16'h0100, (68'd1 << 66) | (68'd1 << 14) | (68'd1 << 13), 3'b100, 4'b0110,
             pk({1'b0, 16'h0100, 64'h8000_0000_0000_0800}, 1, 0, 1, 3'b100, 4'b0110, 0, 0));
        send(0, 16'hFFFF, (68'd1 << 67) | (68'd1 << 1), 3'b000, 4'b0100,
             pk({1'b0, 16'hFFFF, 64'h8000_0000_0000_0000}, 0, 1, 0, 3'b000, 4'b0100, 0, 1));
        send(1, 16'h1000, 68'd1, 3'b101, 4'b0000,
             pk({1'b1, 16'h0FBE, 64'h8000_0000_0000_0000}, 0, 0, 0, 3'b101, 4'b0000, 0, 0));
        send(0, 16'h0006, 68'd1 << 60, 3'b000, 4'b1000,
             pk({1'b0, 16'h0000, 64'h8000_0000_0000_0000}, 0, 0, 0, 3'b000, 4'b1000, 0, 0));
        chk("no_bubble", 93'(n_waits), 93'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("drain1", 93'(exp_q.size()), 93'd0);

        // backpressure: 4 ops, out_rdy low for several cycles
        bus.out_rdy = 1'b0;
        fork
            begin
                send(0, 16'h0100, 68'd1 << 66, 3'b000, 4'b0000,
                     pk({1'b0, 16'h0100, 64'h8000_0000_0000_0000}, 0, 0, 0, 3'b000, 4'b0000, 0, 0));
                send(0, 16'h0100, 68'd1 << 65, 3'b001, 4'b0000,
                     pk({1'b0, 16'h00FF, 64'h8000_0000_0000_0000}, 0, 0, 0, 3'b001, 4'b0000, 0, 0));
                send(1, 16'h0100, 68'd1 << 64, 3'b010, 4'b0000,
                     pk({1'b1, 16'h00FE, 64'h8000_0000_0000_0000}, 0, 0, 0, 3'b010, 4'b0000, 0, 0));
                send(0, 16'h0200, (68'd1 << 66) | (68'd1 << 44), 3'b011, 4'b0000,
                     pk({1'b0, 16'h0200, 64'h8000_0200_0000_0000}, 0, 0, 0, 3'b011, 4'b0000, 0, 0));
            end
            begin
                repeat (3) @(negedge clk);
                chk("bp_in_rdy", {92'd0, bus.in_rdy}, 93'd0);
                chk("bp_out_vld", {92'd0, bus.out_vld}, 93'd1);
                chk("bp_head", dut_out(),
                    pk({1'b0, 16'h0100, 64'h8000_0000_0000_0000}, 0, 0, 0, 3'b000, 4'b0000, 0, 0));
                snap = dut_out();
                repeat (2) begin
                    @(negedge clk);
                    chk("bp_stable", dut_out(), snap);
                    chk("bp_in_rdy_hold", {92'd0, bus.in_rdy}, 93'd0);
                end
                @(posedge clk);
                #1;
                bus.out_rdy = 1'b1;
            end
        join
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        chk("drain2", 93'(exp_q.size()), 93'd0);

`ifdef FPNORM_FLUSH_EN
        // fill both stages, then flush together with a new input
        bus.out_rdy = 1'b0;
        bus.in_vld = 1'b1; bus.in_exp = 16'h0100; bus.in_mant = 68'd1 << 66;
        repeat (2) @(posedge clk);
        #1;
        bus.in_flush = 1'b1;
        bus.out_rdy  = 1'b1;
        @(posedge clk);
        #1;
        bus.in_flush = 1'b0;
        bus.in_vld   = 1'b0;
        @(negedge clk);
        chk("flush_out_vld", {92'd0, bus.out_vld}, 93'd0);
        chk("flush_in_rdy", {92'd0, bus.in_rdy}, 93'd1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("flush_empty", {92'd0, bus.out_vld}, 93'd0);
        @(posedge clk);
        #1;
`endif

        // asynchronous reset with an op sitting in stage 2
        bus.out_rdy = 1'b0;
        send(0, 16'h0100, 68'd1 << 66, 3'b000, 4'b0000, 93'd0);
        @(posedge clk);
        @(negedge clk);
        chk("pre_rst_vld", {92'd0, bus.out_vld}, 93'd1);
        #1;
        rst = 1'b0;
        #1;
        chk("async_rst_vld", {92'd0, bus.out_vld}, 93'd0);
        chk("async_rst_rdy", {92'd0, bus.in_rdy}, 93'd1);
        chk("async_rst_out", dut_out(), 93'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.out_rdy = 1'b1;
        repeat (2) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
